// File: rtl/axi_tdd_ng_mw_core.sv
// TDD timing core: one frame counter drives up to 32 channel gates, each with
// several on/off windows. Configuration is double-buffered and only swapped in
// at frame boundaries (or on entry to ARMED) once a load has been requested.
module axi_tdd_ng_mw_core #(
    parameter int unsigned CHANNEL_COUNT     = 8,
    parameter int unsigned WINDOW_COUNT      = 4,
    parameter int unsigned REGISTER_WIDTH    = 32,
    parameter int unsigned BURST_COUNT_WIDTH = 32
) (
    input  logic                                                clk,
    input  logic                                                resetn,
    input  logic                                                tdd_enable,
    input  logic                                                tdd_sync,
    input  logic [BURST_COUNT_WIDTH-1:0]                        tdd_burst_count,
    input  logic [REGISTER_WIDTH-1:0]                           tdd_startup_delay,
    input  logic [REGISTER_WIDTH-1:0]                           tdd_frame_length,
    input  logic [CHANNEL_COUNT-1:0]                            tdd_channel_en,
    input  logic [CHANNEL_COUNT-1:0]                            tdd_channel_pol,
    input  logic [CHANNEL_COUNT*WINDOW_COUNT*REGISTER_WIDTH-1:0] tdd_window_on,
    input  logic [CHANNEL_COUNT*WINDOW_COUNT*REGISTER_WIDTH-1:0] tdd_window_off,
    input  logic                                                tdd_cfg_load,
    output logic                                                tdd_cfg_pending,
    output logic [CHANNEL_COUNT-1:0]                            tdd_channel,
    output logic [1:0]                                          tdd_cstate,
    output logic [REGISTER_WIDTH-1:0]                           tdd_counter,
    output logic [BURST_COUNT_WIDTH-1:0]                        tdd_frame_cnt,
    output logic                                                tdd_endof_frame,
    output logic                                                tdd_done
);

    localparam int unsigned WinBits = CHANNEL_COUNT * WINDOW_COUNT * REGISTER_WIDTH;
    localparam logic [REGISTER_WIDTH-1:0]    RegOne   = REGISTER_WIDTH'(1);
    localparam logic [BURST_COUNT_WIDTH-1:0] BurstOne = BURST_COUNT_WIDTH'(1);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StArmed   = 2'd1,
        StWaiting = 2'd2,
        StRunning = 2'd3
    } state_e;

    state_e                       state_q, state_d;
    logic [REGISTER_WIDTH-1:0]    counter_q, counter_d;
    logic [BURST_COUNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
    logic [CHANNEL_COUNT-1:0]     raw_q, raw_d;
    logic [CHANNEL_COUNT-1:0]     channel_q, channel_d;
    logic                         done_q, done_d;
    logic                         pending_q, pending_d;

    // Active (shadow) configuration
    logic [BURST_COUNT_WIDTH-1:0] burst_q, burst_d;
    logic [REGISTER_WIDTH-1:0]    delay_q, delay_d;
    logic [REGISTER_WIDTH-1:0]    flen_q, flen_d;
    logic [CHANNEL_COUNT-1:0]     en_q, en_d;
    logic [CHANNEL_COUNT-1:0]     pol_q, pol_d;
    logic [WinBits-1:0]           on_q, on_d;
    logic [WinBits-1:0]           off_q, off_d;

    logic                         eof;
    logic [REGISTER_WIDTH-1:0]    flen_last;
    logic [BURST_COUNT_WIDTH-1:0] frame_cnt_inc;
    logic [CHANNEL_COUNT-1:0]     set_v, clr_v;
    logic                         entering_armed;
    logic                         load_req;
    logic                         cfg_apply;

    // Frame length 0 wraps to the full counter range via modular subtraction
    assign flen_last     = flen_q - RegOne;
    assign eof           = (state_q == StRunning) && (counter_q == flen_last);
    assign frame_cnt_inc = (frame_cnt_q == '1) ? frame_cnt_q : frame_cnt_q + BurstOne;

    // Sequencer: state, counter, frame count and done pulse
    always_comb begin
        state_d     = state_q;
        counter_d   = counter_q;
        frame_cnt_d = frame_cnt_q;
        done_d      = 1'b0;
        case (state_q)
            StIdle: begin
                counter_d = '0;
                if (tdd_enable) begin
                    state_d     = StArmed;
                    frame_cnt_d = '0;
                end
            end
            StArmed: begin
                counter_d = '0;
                if (tdd_sync) begin
                    state_d = (delay_q == '0) ? StRunning : StWaiting;
                end
            end
            StWaiting: begin
                if (counter_q == delay_q - RegOne) begin
                    state_d   = StRunning;
                    counter_d = '0;
                end else begin
                    counter_d = counter_q + RegOne;
                end
            end
            StRunning: begin
                if (eof) begin
                    counter_d   = '0;
                    frame_cnt_d = frame_cnt_inc;
                    if ((burst_q != '0) && (frame_cnt_inc == burst_q)) begin
                        state_d     = StArmed;
                        done_d      = 1'b1;
                        frame_cnt_d = '0;
                    end
                end else begin
                    counter_d = counter_q + RegOne;
                end
            end
            default: state_d = StIdle;
        endcase
        // Disable overrides everything; frame count is kept for inspection
        if (!tdd_enable) begin
            state_d     = StIdle;
            counter_d   = '0;
            frame_cnt_d = frame_cnt_q;
            done_d      = 1'b0;
        end
    end

    // Window matching and registered gate outputs
    always_comb begin
        set_v = '0;
        clr_v = '0;
        for (int unsigned ch = 0; ch < CHANNEL_COUNT; ch++) begin
            for (int unsigned w = 0; w < WINDOW_COUNT; w++) begin
                if (counter_q == on_q[(ch*WINDOW_COUNT+w)*REGISTER_WIDTH +: REGISTER_WIDTH]) begin
                    set_v[ch] = 1'b1;
                end
                if (counter_q == off_q[(ch*WINDOW_COUNT+w)*REGISTER_WIDTH +: REGISTER_WIDTH]) begin
                    clr_v[ch] = 1'b1;
                end
            end
        end
        raw_d = '0;
        // Clear beats set; the frame boundary forces every window shut
        if ((state_q == StRunning) && tdd_enable && !eof) begin
            raw_d = (raw_q | set_v) & ~clr_v;
        end
        channel_d = (state_d == StIdle) ? '0 : (en_q & (raw_d ^ pol_q));
    end

    // Shadow config: follow inputs in IDLE, otherwise swap at a boundary on request
    always_comb begin
        entering_armed = (state_d == StArmed) && (state_q != StArmed);
        load_req       = pending_q | tdd_cfg_load;
        cfg_apply      = (state_q == StIdle) || (load_req && (eof || entering_armed));
        pending_d      = ((state_q == StIdle) || cfg_apply) ? 1'b0 : load_req;
        burst_d        = burst_q;
        delay_d        = delay_q;
        flen_d         = flen_q;
        en_d           = en_q;
        pol_d          = pol_q;
        on_d           = on_q;
        off_d          = off_q;
        if (cfg_apply) begin
            burst_d = tdd_burst_count;
            delay_d = tdd_startup_delay;
            flen_d  = tdd_frame_length;
            en_d    = tdd_channel_en;
            pol_d   = tdd_channel_pol;
            on_d    = tdd_window_on;
            off_d   = tdd_window_off;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= StIdle;
            counter_q   <= '0;
            frame_cnt_q <= '0;
            raw_q       <= '0;
            channel_q   <= '0;
            done_q      <= 1'b0;
            pending_q   <= 1'b0;
            burst_q     <= '0;
            delay_q     <= '0;
            flen_q      <= '0;
            en_q        <= '0;
            pol_q       <= '0;
            on_q        <= '0;
            off_q       <= '0;
        end else begin
            state_q     <= state_d;
            counter_q   <= counter_d;
            frame_cnt_q <= frame_cnt_d;
            raw_q       <= raw_d;
            channel_q   <= channel_d;
            done_q      <= done_d;
            pending_q   <= pending_d;
            burst_q     <= burst_d;
            delay_q     <= delay_d;
            flen_q      <= flen_d;
            en_q        <= en_d;
            pol_q       <= pol_d;
            on_q        <= on_d;
            off_q       <= off_d;
        end
    end

    assign tdd_cfg_pending = pending_q;
    assign tdd_channel     = channel_q;
    assign tdd_cstate      = state_q;
    assign tdd_counter     = counter_q;
    assign tdd_frame_cnt   = frame_cnt_q;
    assign tdd_endof_frame = eof;
    assign tdd_done        = done_q;

endmodule

// File: tb/tb_axi_tdd_ng_mw_core.sv
// Scoreboard bench for axi_tdd_ng_mw_core: expected per-cycle records are
// queued from a behavioural frame model when a burst is launched, then popped
// and compared one per clock.
module tb_axi_tdd_ng_mw_core;

    localparam int CH = 4;
    localparam int W  = 3;
    localparam int RW = 4;
    localparam int BW = 8;

    logic                 clk = 1'b0;
    logic                 resetn;
    logic                 tdd_enable;
    logic                 tdd_sync;
    logic [BW-1:0]        tdd_burst_count;
    logic [RW-1:0]        tdd_startup_delay;
    logic [RW-1:0]        tdd_frame_length;
    logic [CH-1:0]        tdd_channel_en;
    logic [CH-1:0]        tdd_channel_pol;
    logic [CH*W*RW-1:0]   tdd_window_on;
    logic [CH*W*RW-1:0]   tdd_window_off;
    logic                 tdd_cfg_load;
    logic                 tdd_cfg_pending;
    logic [CH-1:0]        tdd_channel;
    logic [1:0]           tdd_cstate;
    logic [RW-1:0]        tdd_counter;
    logic [BW-1:0]        tdd_frame_cnt;
    logic                 tdd_endof_frame;
    logic                 tdd_done;

    always #5 clk = ~clk;

    axi_tdd_ng_mw_core #(
        .CHANNEL_COUNT    (CH),
        .WINDOW_COUNT     (W),
        .REGISTER_WIDTH   (RW),
        .BURST_COUNT_WIDTH(BW)
    ) u_dut (
        .clk              (clk),
        .resetn           (resetn),
        .tdd_enable       (tdd_enable),
        .tdd_sync         (tdd_sync),
        .tdd_burst_count  (tdd_burst_count),
        .tdd_startup_delay(tdd_startup_delay),
        .tdd_frame_length (tdd_frame_length),
        .tdd_channel_en   (tdd_channel_en),
        .tdd_channel_pol  (tdd_channel_pol),
        .tdd_window_on    (tdd_window_on),
        .tdd_window_off   (tdd_window_off),
        .tdd_cfg_load     (tdd_cfg_load),
        .tdd_cfg_pending  (tdd_cfg_pending),
        .tdd_channel      (tdd_channel),
        .tdd_cstate       (tdd_cstate),
        .tdd_counter      (tdd_counter),
        .tdd_frame_cnt    (tdd_frame_cnt),
        .tdd_endof_frame  (tdd_endof_frame),
        .tdd_done         (tdd_done)
    );

    typedef struct packed {
        logic [1:0]    st;
        logic [RW-1:0] cnt;
        logic [CH-1:0] ch;
        logic          eof;
        logic          done;
        logic          pend;
        logic [BW-1:0] fcnt;
    } rec_t;

    rec_t          exp_q[$];
    int            n_checks = 0;
    int            n_errors = 0;
    string         phase = "init";

    int            m_on [CH][W];
    int            m_off[CH][W];
    logic [CH-1:0] m_en;
    logic [CH-1:0] m_pol;
    int            m_fl;
    int            m_delay;
    int            m_burst;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [CH-1:0] out_of(input logic [CH-1:0] raw);
        return m_en & (raw ^ m_pol);
    endfunction

    task automatic drive_cfg();
        tdd_burst_count   = BW'(m_burst);
        tdd_startup_delay = RW'(m_delay);
        tdd_frame_length  = RW'(m_fl);
        tdd_channel_en    = m_en;
        tdd_channel_pol   = m_pol;
        for (int c = 0; c < CH; c++) begin
            for (int w = 0; w < W; w++) begin
                tdd_window_on [(c*W+w)*RW +: RW] = RW'(m_on[c][w]);
                tdd_window_off[(c*W+w)*RW +: RW] = RW'(m_off[c][w]);
            end
        end
    endtask

    task automatic clear_windows();
        for (int c = 0; c < CH; c++) begin
            for (int w = 0; w < W; w++) begin
                m_on[c][w]  = 15;
                m_off[c][w] = 15;
            end
        end
    endtask

    task automatic push(input int st, input int cnt, input logic [CH-1:0] ch, input bit eof,
                        input bit done, input bit pend, input int fcnt);
        rec_t r;
        r.st   = 2'(st);
        r.cnt  = RW'(cnt);
        r.ch   = ch;
        r.eof  = eof;
        r.done = done;
        r.pend = pend;
        r.fcnt = BW'(fcnt);
        exp_q.push_back(r);
    endtask

    task automatic push_wait(input int delay);
        for (int i = 0; i < delay; i++) push(2, i, out_of('0), 0, 0, 0, 0);
    endtask

    // One RUNNING frame: output at counter c reflects window state after counter c-1
    task automatic push_frame(input int fl, input int fcnt, input int pend_from, input int ncyc);
        logic [CH-1:0] r, rn, s, k, cur;
        r   = '0;
        cur = out_of('0);
        for (int c = 0; c < ncyc; c++) begin
            push(3, c, cur, c == fl - 1, 0, c >= pend_from, fcnt);
            s = '0;
            k = '0;
            for (int ch = 0; ch < CH; ch++) begin
                for (int w = 0; w < W; w++) begin
                    if (m_on[ch][w] == c)  s[ch] = 1'b1;
                    if (m_off[ch][w] == c) k[ch] = 1'b1;
                end
            end
            rn = (r | s) & ~k;
            if (c == fl - 1) rn = '0;
            cur = out_of(rn);
            r   = rn;
        end
    endtask

    task automatic push_done();
        push(1, 0, out_of('0), 0, 1, 0, 0);
        push(1, 0, out_of('0), 0, 0, 0, 0);
    endtask

    task automatic run(input int n, input int load_idx, input int load_fl, input int abort_idx);
        rec_t e;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check_eq($sformatf("%s.sb_avail@%0d", phase, i), 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_eq($sformatf("%s.cstate@%0d", phase, i), 32'(tdd_cstate), 32'(e.st));
                check_eq($sformatf("%s.counter@%0d", phase, i), 32'(tdd_counter), 32'(e.cnt));
                check_eq($sformatf("%s.channel@%0d", phase, i), 32'(tdd_channel), 32'(e.ch));
                check_eq($sformatf("%s.eof@%0d", phase, i), 32'(tdd_endof_frame), 32'(e.eof));
                check_eq($sformatf("%s.done@%0d", phase, i), 32'(tdd_done), 32'(e.done));
                check_eq($sformatf("%s.pending@%0d", phase, i), 32'(tdd_cfg_pending), 32'(e.pend));
                check_eq($sformatf("%s.frame_cnt@%0d", phase, i), 32'(tdd_frame_cnt), 32'(e.fcnt));
            end
            tdd_sync     = 1'b0;
            tdd_cfg_load = (i == load_idx);
            if (i == load_idx) tdd_frame_length = RW'(load_fl);
            if (i == abort_idx) tdd_enable = 1'b0;
        end
        check_eq($sformatf("%s.sb_drain", phase), 32'(exp_q.size()), 0);
    endtask

    // Pass through IDLE (config follows inputs there) and into ARMED
    task automatic arm(input int fcnt_idle);
        tdd_enable = 1'b0;
        push(0, 0, '0, 0, 0, 0, fcnt_idle);
        push(0, 0, '0, 0, 0, 0, fcnt_idle);
        run(2, -1, 0, -1);
        tdd_enable = 1'b1;
        push(1, 0, out_of('0), 0, 0, 0, 0);
        run(1, -1, 0, -1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        resetn         = 1'b0;
        tdd_enable     = 1'b1;
        tdd_sync       = 1'b0;
        tdd_cfg_load   = 1'b0;
        m_en           = 4'b1111;
        m_pol          = 4'b1111;
        m_fl           = 10;
        m_delay        = 3;
        m_burst        = 2;
        clear_windows();
        drive_cfg();

        // Reset holds everything at zero even with enable and sync active
        phase = "reset";
        for (int i = 0; i < 4; i++) begin
            tdd_sync = (i % 2) == 0;
            @(posedge clk);
            #1;
            check_eq($sformatf("reset.cstate@%0d", i), 32'(tdd_cstate), 0);
            check_eq($sformatf("reset.channel@%0d", i), 32'(tdd_channel), 0);
            check_eq($sformatf("reset.counter@%0d", i), 32'(tdd_counter), 0);
            check_eq($sformatf("reset.done@%0d", i), 32'(tdd_done), 0);
            check_eq($sformatf("reset.eof@%0d", i), 32'(tdd_endof_frame), 0);
            check_eq($sformatf("reset.frame_cnt@%0d", i), 32'(tdd_frame_cnt), 0);
        end
        tdd_sync   = 1'b0;
        tdd_enable = 1'b0;
        resetn     = 1'b1;

        // Basic, multi-window and polarity/enable channels in one 2-frame burst
        phase = "basic";
        clear_windows();
        m_on[0][0] = 2;  m_off[0][0] = 5;
        m_on[1][0] = 1;  m_off[1][0] = 3;
        m_on[1][1] = 6;  m_off[1][1] = 8;
        m_on[1][2] = 8;  m_off[1][2] = 9;
        m_on[2][0] = 4;  m_off[2][0] = 6;
        m_on[3][0] = 2;  m_off[3][0] = 5;
        m_en    = 4'b0111;
        m_pol   = 4'b1100;
        m_fl    = 10;
        m_delay = 3;
        m_burst = 2;
        drive_cfg();
        arm(0);
        tdd_sync = 1'b1;
        push_wait(3);
        push_frame(10, 0, 99, 10);
        push_frame(10, 1, 99, 10);
        push_done();
        run(3 + 20 + 2, -1, 0, -1);

        // Shadow load: frame length 10 -> 6 requested at counter 4 of the first frame
        phase = "shadow";
        m_burst = 3;
        drive_cfg();
        arm(0);
        tdd_sync = 1'b1;
        push_wait(3);
        push_frame(10, 0, 5, 10);
        push_frame(6, 1, 99, 6);
        push_frame(6, 2, 99, 6);
        push_done();
        run(3 + 22 + 2, 7, 6, -1);

        // Abort at counter 5 of frame 2, zero startup delay, infinite burst
        phase = "abort";
        m_fl    = 10;
        m_delay = 0;
        m_burst = 0;
        drive_cfg();
        arm(0);
        tdd_sync = 1'b1;
        push_frame(10, 0, 99, 10);
        push_frame(10, 1, 99, 6);
        push(0, 0, '0, 0, 0, 0, 1);
        run(17, -1, 0, 15);

        // Frame length 0 gives a full 16-cycle frame; on=off=3 never asserts
        phase = "wrap";
        clear_windows();
        m_on[0][0] = 3;  m_off[0][0] = 3;
        m_on[1][0] = 12; m_off[1][0] = 14;
        m_en    = 4'b0011;
        m_pol   = 4'b0000;
        m_fl    = 0;
        m_delay = 1;
        m_burst = 1;
        drive_cfg();
        arm(1);
        tdd_sync = 1'b1;
        push_wait(1);
        push_frame(16, 0, 99, 16);
        push_done();
        run(1 + 16 + 2, -1, 0, -1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/axi_tdd_ng_mw_core.md
Name: axi_tdd_ng_mw_core

Overview:
Next-generation TDD timing core. Generates up to 32 channel gates from one frame counter, with multiple on/off windows per channel instead of one. Adds double-buffered (shadow) configuration, applied only at frame boundaries, plus a frame counter and done status. Sits behind the TDD register map, in the TDD clock domain. Config inputs are already synchronised to clk.

Parameters:
CHANNEL_COUNT, 8, number of channel outputs (1..32)
WINDOW_COUNT, 4, on/off windows per channel (1..8)
REGISTER_WIDTH, 32, counter/timing width
BURST_COUNT_WIDTH, 32, burst/frame count width

Ports:
clk  in  1  TDD clock
resetn  in  1  synchronous active-low reset
tdd_enable  in  1  global enable
tdd_sync  in  1  single-cycle start pulse
tdd_burst_count  in  BURST_COUNT_WIDTH  frames per burst; 0 = infinite
tdd_startup_delay  in  REGISTER_WIDTH  cycles from sync to first frame
tdd_frame_length  in  REGISTER_WIDTH  cycles per frame
tdd_channel_en  in  CHANNEL_COUNT  per-channel enable
tdd_channel_pol  in  CHANNEL_COUNT  per-channel polarity invert
tdd_window_on  in  CHANNEL_COUNT*WINDOW_COUNT*REGISTER_WIDTH  set times; slice index = ch*WINDOW_COUNT+w
tdd_window_off  in  same  clear times, same indexing
tdd_cfg_load  in  1  request to apply new config at next boundary
tdd_cfg_pending  out  1  load requested, not yet applied
tdd_channel  out  CHANNEL_COUNT  gate outputs
tdd_cstate  out  2  IDLE=0, ARMED=1, WAITING=2, RUNNING=3
tdd_counter  out  REGISTER_WIDTH  current count
tdd_frame_cnt  out  BURST_COUNT_WIDTH  frames completed in current burst
tdd_endof_frame  out  1  high on the last cycle of each frame
tdd_done  out  1  one-cycle pulse at burst completion

Behaviour:
- Reset (resetn=0 at a clk edge): state IDLE, all outputs 0, raw window state 0, active config = 0, pending = 0.
- Active config is a shadow of all config inputs.
  - In IDLE it is loaded from the inputs every cycle.
  - Outside IDLE, tdd_cfg_load sets pending. Active config is then loaded on the cycle after endof_frame, or on entry to ARMED, and pending clears.
  - A load request coinciding with endof_frame is applied at that boundary.
  - Inputs must be held stable while pending.
- FSM:
  - IDLE -> ARMED when tdd_enable=1. Entering ARMED clears frame_cnt.
  - ARMED -> WAITING on tdd_sync. If startup_delay=0, go directly to RUNNING; counter is 0 on the first RUNNING cycle.
  - WAITING counts 0..startup_delay-1, then RUNNING with counter=0.
  - RUNNING counts 0..frame_length-1 and wraps to 0. Compare uses frame_length-1 modulo 2^REGISTER_WIDTH, so frame_length=0 gives a 2^REGISTER_WIDTH frame.
  - At endof_frame, frame_cnt increments (saturating). If burst_count!=0 and the new frame_cnt equals burst_count: tdd_done pulses the following cycle, state -> ARMED, counter -> 0. Otherwise the next frame starts.
  - tdd_sync is ignored in WAITING and RUNNING.
  - tdd_enable=0 in any state -> IDLE next cycle; counter, raw and tdd_channel cleared, frame_cnt held.
  - Counter is 0 in IDLE and ARMED.
- Windows (evaluated only in RUNNING), per channel:
  - set = OR of (counter==on[w]); clr = OR of (counter==off[w]).
  - raw_next = (raw | set) & ~clr, so clear wins on a simultaneous set and clear.
  - On endof_frame, raw_next = 0 (forces open windows shut); a set match at 0 takes effect in the next frame.
  - Windows with on>=frame_length never fire.
- Output: tdd_channel[i] registered = en[i] & (raw_next[i] ^ pol[i]).
  - Latency: one cycle from the counter value to the output change.
  - An enabled, inverted channel outputs 1 in ARMED/WAITING; the output is 0 in IDLE.
- tdd_endof_frame is combinational from the registered state: RUNNING && counter==frame_length-1.
- Mid-operation reset: immediate return to reset values on the next edge, regardless of state.

Test Plan:
- Reset with enable=1, sync pulsing -> all outputs 0, cstate=0 while resetn=0.
- Basic frame: CH0 on=2,off=5, frame=10, delay=3, burst=2, sync at t0 -> RUNNING at t0+4 with counter 0; CH0 high for counter 3..5 each frame; endof_frame at counter 9; done pulses once after frame 2; cstate returns to ARMED.
- Multi-window: CH1 windows (1,3),(6,8),(8,9); frame=10 -> CH1 high at counter 2-3 and 7-8; at counter 9 the set at 8 and the clear at 8 coincide, clear wins, so CH1 is low at counter 9.
- Polarity/enable: CH2 pol=1, en=1 -> 1 in ARMED, 0 inside window; en=0 -> constant 0.
- Shadow load: change frame_length 10->6 with cfg_load at counter 4 -> pending=1 until the boundary; the current frame finishes at counter 9; the next frame wraps at counter 5; pending=0.
- Abort and edges: disable at counter 5 -> IDLE next cycle with outputs 0. frame_length=0 with REGISTER_WIDTH=4 -> 16-cycle frame. Window with on=off=3 never asserts.
